// File: rtl/ex_stage_controller.sv
// Execute-stage sequencer: retires single-cycle ops at once, holds the pipe for
// multi-cycle mul/div/mod, raises flush on taken branches and counts events.
module ex_stage_controller #(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             isMul,
    input  logic             isDiv,
    input  logic             isMod,
    input  logic             isBranchTaken,
    input  logic             ma_stall,
    output logic             stall,
    output logic             flush,
    output logic             ex_latch_en,
    output logic             mawb_valid,
    output logic             busy,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        IDLE,
        MULTI
    } stateT;

    // The accept cycle and the final latch cycle each consume one cycle of occupancy.
    localparam logic [7:0]       MUL_RELOAD = 8'(MUL_CYCLES - 2);
    localparam logic [7:0]       DIV_RELOAD = 8'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    stateT      state, nextState;
    logic [7:0] cnt, nextCnt;
    logic       latDiv, nextLatDiv;
    logic       multiOp, useDiv;

    assign multiOp = isMul | isDiv | isMod;
    assign useDiv  = isDiv | isMod;

    always_comb begin
        nextState   = state;
        nextCnt     = cnt;
        nextLatDiv  = latDiv;
        stall       = 1'b0;
        ex_latch_en = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (multiOp) begin
                        stall      = 1'b1;
                        nextState  = MULTI;
                        nextCnt    = useDiv ? DIV_RELOAD : MUL_RELOAD;
                        nextLatDiv = useDiv;
                    end else begin
                        ex_latch_en = !ma_stall;
                        stall       = ma_stall;
                    end
                end
            end
            MULTI: begin
                if (cnt != 8'd0) begin
                    stall   = 1'b1;
                    nextCnt = cnt - 8'd1;
                end else if (ma_stall) begin
                    stall = 1'b1;
                end else begin
                    ex_latch_en = 1'b1;
                    nextState   = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        // Reset must silence the pipeline controls in the same cycle it is seen.
        if (reset) begin
            stall       = 1'b0;
            ex_latch_en = 1'b0;
        end
    end

    assign flush = ex_latch_en & isBranchTaken;
    assign busy  = (state == MULTI) & !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            latDiv      <= 1'b0;
            mawb_valid  <= 1'b0;
            retired_cnt <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            latDiv     <= nextLatDiv;
            mawb_valid <= ex_latch_en;
            if (ex_latch_en) retired_cnt <= retired_cnt + CNT_ONE;
            if (stall)       stall_cnt   <= stall_cnt + CNT_ONE;
            if (flush)       flush_cnt   <= flush_cnt + CNT_ONE;
        end
    end

    // The remaining count can never exceed the reload of the op class that was accepted.
    always_ff @(posedge clk) begin
        if (!reset && state == MULTI)
            assert (cnt <= (latDiv ? DIV_RELOAD : MUL_RELOAD));
    end

endmodule

// File: tb/tb_ex_stage_controller.sv
// Directed bench for ex_stage_controller: default-parameter instance plus a
// narrow-counter instance used for the wrap-around check.
module tb_ex_stage_controller;

    logic clk = 1'b0;
    logic reset, inValid, isMul, isDiv, isMod, isBranchTaken, maStall;

    logic        stall, flush, exLatchEn, mawbValid, busy;
    logic [31:0] retiredCnt, stallCnt, flushCnt;

    logic       nStall, nFlush, nExLatchEn, nMawbValid, nBusy;
    logic [3:0] nRetiredCnt, nStallCnt, nFlushCnt;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    ex_stage_controller dut (
        .clk(clk), .reset(reset), .in_valid(inValid), .isMul(isMul), .isDiv(isDiv),
        .isMod(isMod), .isBranchTaken(isBranchTaken), .ma_stall(maStall),
        .stall(stall), .flush(flush), .ex_latch_en(exLatchEn), .mawb_valid(mawbValid),
        .busy(busy), .retired_cnt(retiredCnt), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    ex_stage_controller #(.CNT_W(4)) dutNarrow (
        .clk(clk), .reset(reset), .in_valid(inValid), .isMul(isMul), .isDiv(isDiv),
        .isMod(isMod), .isBranchTaken(isBranchTaken), .ma_stall(maStall),
        .stall(nStall), .flush(nFlush), .ex_latch_en(nExLatchEn), .mawb_valid(nMawbValid),
        .busy(nBusy), .retired_cnt(nRetiredCnt), .stall_cnt(nStallCnt), .flush_cnt(nFlushCnt)
    );

    task automatic applyStimulus(input logic v, input logic m, input logic d,
                                 input logic mo, input logic b, input logic ms);
        inValid = v; isMul = m; isDiv = d; isMod = mo; isBranchTaken = b; maStall = ms;
    endtask

    task automatic nextCycle;
        @(posedge clk); #1;
    endtask

    task automatic doReset;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        applyStimulus(1, 1, 0, 0, 1, 0);
        @(negedge clk);
        assertCount++; if (stall !== 1'b0)     begin failCount++; $display("[TB] FAIL reset stall: got %b want 0", stall); end
        assertCount++; if (exLatchEn !== 1'b0) begin failCount++; $display("[TB] FAIL reset ex_latch_en: got %b want 0", exLatchEn); end
        assertCount++; if (flush !== 1'b0)     begin failCount++; $display("[TB] FAIL reset flush: got %b want 0", flush); end
        assertCount++; if (busy !== 1'b0)      begin failCount++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (mawbValid !== 1'b0)   begin failCount++; $display("[TB] FAIL reset mawb_valid: got %b want 0", mawbValid); end
        assertCount++; if (retiredCnt !== 32'd0) begin failCount++; $display("[TB] FAIL reset retired_cnt: got %0d want 0", retiredCnt); end
        assertCount++; if (stallCnt !== 32'd0)   begin failCount++; $display("[TB] FAIL reset stall_cnt: got %0d want 0", stallCnt); end
        assertCount++; if (flushCnt !== 32'd0)   begin failCount++; $display("[TB] FAIL reset flush_cnt: got %0d want 0", flushCnt); end
        reset = 1'b0;
        @(negedge clk);
        assertCount++; if (busy !== 1'b0)  begin failCount++; $display("[TB] FAIL idle busy: got %b want 0", busy); end
        assertCount++; if (stall !== 1'b0) begin failCount++; $display("[TB] FAIL idle stall: got %b want 0", stall); end
        nextCycle();
    endtask

    task automatic test_single;
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        assertCount++; if (exLatchEn !== 1'b1) begin failCount++; $display("[TB] FAIL single ex_latch_en: got %b want 1", exLatchEn); end
        assertCount++; if (stall !== 1'b0)     begin failCount++; $display("[TB] FAIL single stall: got %b want 0", stall); end
        assertCount++; if (flush !== 1'b0)     begin failCount++; $display("[TB] FAIL single flush: got %b want 0", flush); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (mawbValid !== 1'b1)   begin failCount++; $display("[TB] FAIL single mawb_valid: got %b want 1", mawbValid); end
        assertCount++; if (retiredCnt !== 32'd1) begin failCount++; $display("[TB] FAIL single retired_cnt: got %0d want 1", retiredCnt); end
        assertCount++; if (stallCnt !== 32'd0)   begin failCount++; $display("[TB] FAIL single stall_cnt: got %0d want 0", stallCnt); end
        nextCycle();
        assertCount++; if (mawbValid !== 1'b0) begin failCount++; $display("[TB] FAIL single mawb_valid drop: got %b want 0", mawbValid); end
    endtask

    task automatic test_mul;
        bit [2:0] expStall = 3'b011;
        bit [2:0] expBusy  = 3'b110;
        bit [2:0] expLatch = 3'b100;
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            @(negedge clk);
            assertCount++; if (stall !== expStall[c])     begin failCount++; $display("[TB] FAIL mul stall c%0d: got %b want %b", c, stall, expStall[c]); end
            assertCount++; if (busy !== expBusy[c])       begin failCount++; $display("[TB] FAIL mul busy c%0d: got %b want %b", c, busy, expBusy[c]); end
            assertCount++; if (exLatchEn !== expLatch[c]) begin failCount++; $display("[TB] FAIL mul ex_latch_en c%0d: got %b want %b", c, exLatchEn, expLatch[c]); end
            if (c == 1) begin
                assertCount++; if (mawbValid !== 1'b0) begin failCount++; $display("[TB] FAIL mul mawb_valid c1: got %b want 0", mawbValid); end
            end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (busy !== 1'b0)        begin failCount++; $display("[TB] FAIL mul busy c3: got %b want 0", busy); end
        assertCount++; if (mawbValid !== 1'b1)   begin failCount++; $display("[TB] FAIL mul mawb_valid c3: got %b want 1", mawbValid); end
        assertCount++; if (stallCnt !== 32'd2)   begin failCount++; $display("[TB] FAIL mul stall_cnt: got %0d want 2", stallCnt); end
        assertCount++; if (retiredCnt !== 32'd1) begin failCount++; $display("[TB] FAIL mul retired_cnt: got %0d want 1", retiredCnt); end
    endtask

    task automatic test_div_priority;
        doReset();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, 1, 1, 0, 0, 0);
            @(negedge clk);
            assertCount++; if (stall !== (c < 7))      begin failCount++; $display("[TB] FAIL div stall c%0d: got %b want %b", c, stall, (c < 7)); end
            assertCount++; if (exLatchEn !== (c == 7)) begin failCount++; $display("[TB] FAIL div ex_latch_en c%0d: got %b want %b", c, exLatchEn, (c == 7)); end
            assertCount++; if (busy !== (c > 0))       begin failCount++; $display("[TB] FAIL div busy c%0d: got %b want %b", c, busy, (c > 0)); end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (stallCnt !== 32'd7) begin failCount++; $display("[TB] FAIL div stall_cnt: got %0d want 7", stallCnt); end
    endtask

    task automatic test_mod_reset;
        doReset();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 0, 0, 1, 0, 0);
            @(negedge clk);
            assertCount++; if (stall !== 1'b1)   begin failCount++; $display("[TB] FAIL mod stall c%0d: got %b want 1", c, stall); end
            assertCount++; if (busy !== (c > 0)) begin failCount++; $display("[TB] FAIL mod busy c%0d: got %b want %b", c, busy, (c > 0)); end
            nextCycle();
        end
        reset = 1'b1;
        @(negedge clk);
        assertCount++; if (stall !== 1'b0)     begin failCount++; $display("[TB] FAIL modrst stall: got %b want 0", stall); end
        assertCount++; if (busy !== 1'b0)      begin failCount++; $display("[TB] FAIL modrst busy: got %b want 0", busy); end
        assertCount++; if (exLatchEn !== 1'b0) begin failCount++; $display("[TB] FAIL modrst ex_latch_en: got %b want 0", exLatchEn); end
        assertCount++; if (flush !== 1'b0)     begin failCount++; $display("[TB] FAIL modrst flush: got %b want 0", flush); end
        nextCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        assertCount++; if (busy !== 1'b0)        begin failCount++; $display("[TB] FAIL modrst idle busy: got %b want 0", busy); end
        assertCount++; if (exLatchEn !== 1'b0)   begin failCount++; $display("[TB] FAIL modrst idle ex_latch_en: got %b want 0", exLatchEn); end
        assertCount++; if (retiredCnt !== 32'd0) begin failCount++; $display("[TB] FAIL modrst retired_cnt: got %0d want 0", retiredCnt); end
        assertCount++; if (stallCnt !== 32'd0)   begin failCount++; $display("[TB] FAIL modrst stall_cnt: got %0d want 0", stallCnt); end
        assertCount++; if (flushCnt !== 32'd0)   begin failCount++; $display("[TB] FAIL modrst flush_cnt: got %0d want 0", flushCnt); end
        nextCycle();
        assertCount++; if (mawbValid !== 1'b0) begin failCount++; $display("[TB] FAIL modrst mawb_valid: got %b want 0", mawbValid); end
    endtask

    task automatic test_branch_stall;
        bit [2:0] maPat = 3'b011;
        doReset();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 0, 0, 0, 1, maPat[c]);
            @(negedge clk);
            assertCount++; if (flush !== (c == 2))     begin failCount++; $display("[TB] FAIL br flush c%0d: got %b want %b", c, flush, (c == 2)); end
            assertCount++; if (stall !== (c < 2))      begin failCount++; $display("[TB] FAIL br stall c%0d: got %b want %b", c, stall, (c < 2)); end
            assertCount++; if (exLatchEn !== (c == 2)) begin failCount++; $display("[TB] FAIL br ex_latch_en c%0d: got %b want %b", c, exLatchEn, (c == 2)); end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (flushCnt !== 32'd1)   begin failCount++; $display("[TB] FAIL br flush_cnt: got %0d want 1", flushCnt); end
        assertCount++; if (stallCnt !== 32'd2)   begin failCount++; $display("[TB] FAIL br stall_cnt: got %0d want 2", stallCnt); end
        assertCount++; if (retiredCnt !== 32'd1) begin failCount++; $display("[TB] FAIL br retired_cnt: got %0d want 1", retiredCnt); end
        assertCount++; if (busy !== 1'b0)        begin failCount++; $display("[TB] FAIL br busy: got %b want 0", busy); end
    endtask

    task automatic test_mul_ma_stall;
        bit [4:0] maPat    = 5'b01101;
        bit [4:0] expStall = 5'b01111;
        bit [4:0] expLatch = 5'b10000;
        doReset();
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 1, 0, 0, 0, maPat[c]);
            @(negedge clk);
            assertCount++; if (stall !== expStall[c])     begin failCount++; $display("[TB] FAIL mulms stall c%0d: got %b want %b", c, stall, expStall[c]); end
            assertCount++; if (exLatchEn !== expLatch[c]) begin failCount++; $display("[TB] FAIL mulms ex_latch_en c%0d: got %b want %b", c, exLatchEn, expLatch[c]); end
            nextCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        assertCount++; if (stallCnt !== 32'd4)   begin failCount++; $display("[TB] FAIL mulms stall_cnt: got %0d want 4", stallCnt); end
        assertCount++; if (retiredCnt !== 32'd1) begin failCount++; $display("[TB] FAIL mulms retired_cnt: got %0d want 1", retiredCnt); end
        assertCount++; if (busy !== 1'b0)        begin failCount++; $display("[TB] FAIL mulms busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] expNarrow;
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            nextCycle();
            if (k >= 15) begin
                expNarrow = (k == 15) ? 4'd15 : (k == 16) ? 4'd0 : 4'd1;
                assertCount++; if (nRetiredCnt !== expNarrow) begin failCount++; $display("[TB] FAIL wrap retired_cnt k%0d: got %0d want %0d", k, nRetiredCnt, expNarrow); end
            end
        end
        @(negedge clk);
        assertCount++; if (nExLatchEn !== 1'b1)   begin failCount++; $display("[TB] FAIL wrap ex_latch_en: got %b want 1", nExLatchEn); end
        assertCount++; if (nMawbValid !== 1'b1)   begin failCount++; $display("[TB] FAIL wrap mawb_valid: got %b want 1", nMawbValid); end
        assertCount++; if (nStall !== 1'b0)       begin failCount++; $display("[TB] FAIL wrap stall: got %b want 0", nStall); end
        assertCount++; if (nFlush !== 1'b0)       begin failCount++; $display("[TB] FAIL wrap flush: got %b want 0", nFlush); end
        assertCount++; if (nBusy !== 1'b0)        begin failCount++; $display("[TB] FAIL wrap busy: got %b want 0", nBusy); end
        assertCount++; if (nStallCnt !== 4'd0)    begin failCount++; $display("[TB] FAIL wrap stall_cnt: got %0d want 0", nStallCnt); end
        assertCount++; if (nFlushCnt !== 4'd0)    begin failCount++; $display("[TB] FAIL wrap flush_cnt: got %0d want 0", nFlushCnt); end
        assertCount++; if (retiredCnt !== 32'd17) begin failCount++; $display("[TB] FAIL wide retired_cnt: got %0d want 17", retiredCnt); end
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        test_reset();
        test_single();
        test_mul();
        test_div_priority();
        test_mod_reset();
        test_branch_stall();
        test_mul_ma_stall();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
